sevseg_display: RTL and testbench

//  Drives a 4-digit, common-anode 7-segment display from the 8-bit output register of the IO block.

---
 rtl/sevseg_display.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sevseg_display.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_display.sv
// -----------------------------------------------------------------------------
// sevseg_display
//   Drives a 4-digit common-anode 7-segment display from the 8-bit IO output
//   register. The value is shown as two hex digits, or, when the optional
//   decimal path is built, as up to three unsigned decimal digits produced by
//   a sequential double-dabble converter. One digit is lit per refresh slot.
//
//   Build option: define SEVSEG_DECIMAL_EN to build the decimal converter and
//   decimal display path. Without it i_decimal is ignored and the block always
//   shows hex.
//
// Ports
//   i_clk       system clock, all state on posedge
//   i_resetn    asynchronous active-low reset
//   i_value     value to display
//   i_decimal   1 = decimal mode, 0 = hex mode
//   o_segments  {g,f,e,d,c,b,a}, active-low
//   o_dp        decimal point, active-low
//   o_anodes    digit enables, active-low, bit0 = rightmost digit
//
// Converter states
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a decimal-mode value that differs from the last
//             | converted one (or a fresh entry into decimal mode)
//   ST_CONV   | 8 cycles: add-3 on every BCD nibble >=5, shift in one bit
//   ST_COMMIT | copy BCD result to the display register, record the value
// -----------------------------------------------------------------------------
module sevseg_display #(
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [7:0] i_value,
  input  logic       i_decimal,
  output logic [6:0] o_segments,
  output logic       o_dp,
  output logic [3:0] o_anodes
);

  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [7:0]       value_q;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             scan_tc;
  logic [6:0]       segments_q, segments_d;
  logic             dp_q, dp_d;
  logic [3:0]       anodes_q, anodes_d;

  // ---------------------------------------------------------------------------
  // Input stage and scan timing
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      value_q     <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
    end else begin
      value_q     <= i_value;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  always_comb begin
    scan_tc     = (scan_cnt_q == CNT_LAST);
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + CNT_W'(1);
    digit_idx_d = scan_tc ? digit_idx_q + 2'd1 : digit_idx_q;
  end

`ifdef SEVSEG_DECIMAL_EN
  // ---------------------------------------------------------------------------
  // Double-dabble converter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  conv_state_e state_q, state_d;
  logic        decimal_q, decimal_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] bcd_adj;
  logic [7:0]  latch_q, latch_d;
  logic [7:0]  last_q, last_d;
  logic        last_valid_q, last_valid_d;
  logic [11:0] disp_bcd_q, disp_bcd_d;
  logic        dec_rise;
  logic        need_conv;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      decimal_q      <= 1'b0;
      decimal_prev_q <= 1'b0;
      bit_cnt_q      <= '0;
      bcd_q          <= '0;
      latch_q        <= '0;
      last_q         <= '0;
      last_valid_q   <= 1'b0;
      disp_bcd_q     <= '0;
    end else begin
      decimal_q      <= i_decimal;
      decimal_prev_q <= decimal_q;
      bit_cnt_q      <= bit_cnt_d;
      bcd_q          <= bcd_d;
      latch_q        <= latch_d;
      last_q         <= last_d;
      last_valid_q   <= last_valid_d;
      disp_bcd_q     <= disp_bcd_d;
    end
  end

  // Entering decimal mode always forces a fresh conversion, even if the value
  // matches what was converted before the mode was left.
  assign dec_rise  = decimal_q & ~decimal_prev_q;
  assign need_conv = decimal_q & (dec_rise | ~last_valid_q | (value_q != last_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (need_conv) state_d = ST_CONV;
      ST_CONV:   if (bit_cnt_q == 3'd7) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    bcd_d        = bcd_q;
    latch_d      = latch_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    disp_bcd_d   = disp_bcd_q;
    bcd_adj      = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    case (state_q)
      ST_IDLE: begin
        if (need_conv) begin
          latch_d   = value_q;
          bit_cnt_d = '0;
          bcd_d     = '0;
        end
      end
      ST_CONV: begin
        // MSB first; the hundreds nibble never exceeds 2 so bcd_adj[11] is 0.
        bcd_d     = {bcd_adj[10:0], latch_q[3'd7 - bit_cnt_q]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      ST_COMMIT: begin
        disp_bcd_d   = bcd_q;
        last_d       = latch_q;
        last_valid_d = 1'b1;
      end
      default: ;
    endcase
    if (dec_rise) last_valid_d = 1'b0;
  end
`else
  logic unused_decimal;
  assign unused_decimal = i_decimal;
`endif

  // ---------------------------------------------------------------------------
  // Digit select and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    logic       blank;
    logic [3:0] nib;
    blank = 1'b1;
    nib   = 4'h0;
    dp_d  = 1'b1;
`ifdef SEVSEG_DECIMAL_EN
    if (decimal_q) begin
      case (digit_idx_q)
        2'd0: begin
          nib   = disp_bcd_q[3:0];
          blank = 1'b0;
        end
        2'd1: begin
          nib   = disp_bcd_q[7:4];
          blank = (disp_bcd_q[11:4] == 8'h00);
        end
        2'd2: begin
          nib   = disp_bcd_q[11:8];
          blank = (disp_bcd_q[11:8] == 4'h0);
        end
        default: blank = 1'b1;
      endcase
    end else
`endif
    begin
      case (digit_idx_q)
        2'd0: begin
          nib   = value_q[3:0];
          blank = 1'b0;
          dp_d  = 1'b0;
        end
        2'd1: begin
          nib   = value_q[7:4];
          blank = 1'b0;
        end
        default: blank = 1'b1;
      endcase
    end
    anodes_d   = blank ? 4'b1111 : ~(4'b0001 << digit_idx_q);
    segments_d = blank ? 7'h7F : seg_font(nib);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      anodes_q   <= 4'b1111;
      segments_q <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      dp_q       <= dp_d;
    end
  end

  assign o_anodes   = anodes_q;
  assign o_segments = segments_q;
  assign o_dp       = dp_q;

endmodule

// File: tb/tb_sevseg_display.sv
module tb_sevseg_display;

  logic       i_clk = 1'b0;
  logic       i_resetn;
  logic [7:0] i_value;
  logic       i_decimal;
  logic [6:0] o_segments;
  logic       o_dp;
  logic [3:0] o_anodes;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Latest segments/dp seen per digit over a capture window.
  logic [3:0] cap_seen;
  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  int         cap_bad;

  sevseg_display #(.REFRESH_CYCLES(4)) dut (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_value    (i_value),
    .i_decimal  (i_decimal),
    .o_segments (o_segments),
    .o_dp       (o_dp),
    .o_anodes   (o_anodes)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic scan_capture(input int ncyc);
    cap_seen = '0;
    cap_bad  = 0;
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 7'h7F;
      cap_dp[i]  = 1'b1;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      case (o_anodes)
        4'b1110: begin cap_seen[0] = 1'b1; cap_seg[0] = o_segments; cap_dp[0] = o_dp; end
        4'b1101: begin cap_seen[1] = 1'b1; cap_seg[1] = o_segments; cap_dp[1] = o_dp; end
        4'b1011: begin cap_seen[2] = 1'b1; cap_seg[2] = o_segments; cap_dp[2] = o_dp; end
        4'b0111: begin cap_seen[3] = 1'b1; cap_seg[3] = o_segments; cap_dp[3] = o_dp; end
        4'b1111: ;
        default: cap_bad++;
      endcase
    end
  endtask

  task automatic test_reset;
    i_resetn  = 1'b0;
    i_value   = 8'hFF;
    i_decimal = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      checks++;
      if (o_anodes !== 4'b1111) begin
        failures++;
        $display("FAIL reset_anodes cycle %0d got %b required 1111", c, o_anodes);
      end
      checks++;
      if (o_segments !== 7'h7F) begin
        failures++;
        $display("FAIL reset_segments cycle %0d got %b required 1111111", c, o_segments);
      end
      checks++;
      if (o_dp !== 1'b1) begin
        failures++;
        $display("FAIL reset_dp cycle %0d got %b required 1", c, o_dp);
      end
    end
  endtask

  task automatic test_scan_timing;
    logic [3:0] exp_an;
    @(negedge i_clk);
    i_value   = 8'hA5;
    i_decimal = 1'b0;
    i_resetn  = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge i_clk);
      if (k <= 4 || k == 17) exp_an = 4'b1110;
      else if (k <= 8)       exp_an = 4'b1101;
      else                   exp_an = 4'b1111;
      checks++;
      if (o_anodes !== exp_an) begin
        failures++;
        $display("FAIL scan_timing edge %0d got %b required %b", k, o_anodes, exp_an);
      end
    end
  endtask

  task automatic test_hex;
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0011 || cap_bad != 0) begin
      failures++;
      $display("FAIL hex_a5_digits got seen=%b bad=%0d required seen=0011 bad=0", cap_seen, cap_bad);
    end
    checks++;
    if (cap_seg[0] !== SEG_5 || cap_dp[0] !== 1'b0) begin
      failures++;
      $display("FAIL hex_a5_digit0 got seg=%b dp=%b required seg=%b dp=0", cap_seg[0], cap_dp[0], SEG_5);
    end
    checks++;
    if (cap_seg[1] !== SEG_A || cap_dp[1] !== 1'b1) begin
      failures++;
      $display("FAIL hex_a5_digit1 got seg=%b dp=%b required seg=%b dp=1", cap_seg[1], cap_dp[1], SEG_A);
    end

    @(negedge i_clk);
    i_value = 8'h3C;
    repeat (3) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0011 || cap_seg[0] !== SEG_C || cap_seg[1] !== SEG_3) begin
      failures++;
      $display("FAIL hex_3c got seen=%b d0=%b d1=%b required seen=0011 d0=%b d1=%b",
               cap_seen, cap_seg[0], cap_seg[1], SEG_C, SEG_3);
    end
  endtask

`ifdef SEVSEG_DECIMAL_EN
  task automatic test_decimal;
    @(negedge i_clk);
    i_decimal = 1'b1;
    i_value   = 8'd255;
    repeat (14) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0111 || cap_bad != 0) begin
      failures++;
      $display("FAIL dec_255_digits got seen=%b bad=%0d required seen=0111 bad=0", cap_seen, cap_bad);
    end
    checks++;
    if (cap_seg[2] !== SEG_2 || cap_seg[1] !== SEG_5 || cap_seg[0] !== SEG_5) begin
      failures++;
      $display("FAIL dec_255_segs got %b/%b/%b required %b/%b/%b",
               cap_seg[2], cap_seg[1], cap_seg[0], SEG_2, SEG_5, SEG_5);
    end
    checks++;
    if (cap_dp[0] !== 1'b1 || cap_dp[1] !== 1'b1 || cap_dp[2] !== 1'b1) begin
      failures++;
      $display("FAIL dec_255_dp got %b%b%b required 111", cap_dp[2], cap_dp[1], cap_dp[0]);
    end

    @(negedge i_clk);
    i_value = 8'd7;
    repeat (14) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0001 || cap_seg[0] !== SEG_7) begin
      failures++;
      $display("FAIL dec_7 got seen=%b d0=%b required seen=0001 d0=%b", cap_seen, cap_seg[0], SEG_7);
    end

    @(negedge i_clk);
    i_value = 8'd105;
    repeat (14) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0111 || cap_seg[2] !== SEG_1 || cap_seg[1] !== SEG_0 || cap_seg[0] !== SEG_5) begin
      failures++;
      $display("FAIL dec_105 got seen=%b %b/%b/%b required seen=0111 %b/%b/%b",
               cap_seen, cap_seg[2], cap_seg[1], cap_seg[0], SEG_1, SEG_0, SEG_5);
    end

    @(negedge i_clk);
    i_value = 8'd0;
    repeat (14) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0001 || cap_seg[0] !== SEG_0) begin
      failures++;
      $display("FAIL dec_0 got seen=%b d0=%b required seen=0001 d0=%b", cap_seen, cap_seg[0], SEG_0);
    end
  endtask

  task automatic test_mid_change;
    int bad;
    bad = 0;
    @(negedge i_clk);
    i_value = 8'd100;
    // Display may only ever show 0, 100 or 42 during this window.
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (c == 3) i_value = 8'd42;
      case (o_anodes)
        4'b1110: if (o_segments !== SEG_0 && o_segments !== SEG_2) bad++;
        4'b1101: if (o_segments !== SEG_0 && o_segments !== SEG_4) bad++;
        4'b1011: if (o_segments !== SEG_1) bad++;
        4'b1111: ;
        default: bad++;
      endcase
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_change_intermediate got %0d bad samples required 0", bad);
    end
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0011 || cap_seg[1] !== SEG_4 || cap_seg[0] !== SEG_2) begin
      failures++;
      $display("FAIL mid_change_final got seen=%b %b/%b required seen=0011 %b/%b",
               cap_seen, cap_seg[1], cap_seg[0], SEG_4, SEG_2);
    end
  endtask

  task automatic test_reset_mid_conv;
    @(negedge i_clk);
    i_value = 8'd200;
    repeat (4) @(negedge i_clk);
    #2;
    i_resetn = 1'b0;
    #1;
    checks++;
    if (o_anodes !== 4'b1111 || o_segments !== 7'h7F || o_dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_conv got an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1",
               o_anodes, o_segments, o_dp);
    end
    i_value = 8'd9;
    repeat (2) @(negedge i_clk);
    i_resetn = 1'b1;
    repeat (12) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0001 || cap_seg[0] !== SEG_9 || cap_bad != 0) begin
      failures++;
      $display("FAIL after_reset_9 got seen=%b d0=%b bad=%0d required seen=0001 d0=%b bad=0",
               cap_seen, cap_seg[0], cap_bad, SEG_9);
    end
  endtask
`else
  task automatic test_hex_forced;
    @(negedge i_clk);
    i_decimal = 1'b1;
    i_value   = 8'd255;
    repeat (4) @(negedge i_clk);
    scan_capture(17);
    checks++;
    if (cap_seen !== 4'b0011 || cap_seg[0] !== SEG_F || cap_seg[1] !== SEG_F) begin
      failures++;
      $display("FAIL hex_forced_ff got seen=%b %b/%b required seen=0011 %b/%b",
               cap_seen, cap_seg[1], cap_seg[0], SEG_F, SEG_F);
    end
    checks++;
    if (cap_dp[0] !== 1'b0 || cap_dp[1] !== 1'b1) begin
      failures++;
      $display("FAIL hex_forced_dp got d1=%b d0=%b required d1=1 d0=0", cap_dp[1], cap_dp[0]);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_scan_timing;
    test_hex;
`ifdef SEVSEG_DECIMAL_EN
    test_decimal;
    test_mid_change;
    test_reset_mid_conv;
`else
    test_hex_forced;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
